// File: rtl/pipeline_pkg.sv
// pipeline_pkg: widths, ALU op encodings and the EX/MEM/WB control bundle
// shared by the ID/EX register and the later pipeline stage registers.
package pipeline_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_AND = 4'h0;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h1;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h2;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h6;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'h7;
  localparam logic [ALUOP_W-1:0] ALU_NOR = 4'hC;

  // Single-bit control travelling with an instruction from EX onwards.
  // An all-zero value is an inert bubble: no write, no memory access, no branch.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags a load in EX whose destination (rt) is read by
// the instruction currently in Decode. Register 0 never creates a hazard.
module load_use_detector #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  // Purely combinational compare so upstream can hold PC and IF/ID this cycle.
  always_comb begin
    hazard = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
             ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_stage_register.sv
// id_ex_stage_register: ID/EX pipeline register with valid bit, stall (hold),
// flush (bubble) and a saturating count of inserted bubbles.
// Define IDEX_LOAD_USE_DETECT_EN to build in a load-use detector that inserts
// bubbles itself; otherwise HazardStall is tied low and an external unit is
// expected to drive Stall/Flush.
module id_ex_stage_register #(
  parameter int DATA_W  = pipeline_pkg::DATA_W,
  parameter int REG_W   = pipeline_pkg::REG_W,
  parameter int ALUOP_W = pipeline_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               ClrCount,
  input  logic               in_Valid,
  input  logic [DATA_W-1:0]  in_PCPlus4,
  input  logic [DATA_W-1:0]  in_ReadData1,
  input  logic [DATA_W-1:0]  in_ReadData2,
  input  logic [DATA_W-1:0]  in_SignExtImm,
  input  logic [REG_W-1:0]   in_Rs,
  input  logic [REG_W-1:0]   in_Rt,
  input  logic [REG_W-1:0]   in_Rd,
  input  logic               in_RegWrite,
  input  logic               in_MemToReg,
  input  logic               in_MemRead,
  input  logic               in_MemWrite,
  input  logic               in_Branch,
  input  logic               in_ALUSrc,
  input  logic               in_RegDst,
  input  logic [ALUOP_W-1:0] in_ALUOP,
  output logic               out_Valid,
  output logic [DATA_W-1:0]  out_PCPlus4,
  output logic [DATA_W-1:0]  out_ReadData1,
  output logic [DATA_W-1:0]  out_ReadData2,
  output logic [DATA_W-1:0]  out_SignExtImm,
  output logic [REG_W-1:0]   out_Rs,
  output logic [REG_W-1:0]   out_Rt,
  output logic [REG_W-1:0]   out_Rd,
  output logic               out_RegWrite,
  output logic               out_MemToReg,
  output logic               out_MemRead,
  output logic               out_MemWrite,
  output logic               out_Branch,
  output logic               out_ALUSrc,
  output logic               out_RegDst,
  output logic [ALUOP_W-1:0] out_ALUOP,
  output logic [CNT_W-1:0]   out_BubbleCount,
  output logic               HazardStall
);

  import pipeline_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t            in_ctrl;
  ctrl_t            ex_ctrl;
  logic             hazard_stall;
  logic             load_bubble;
  logic             count_bubble;
  logic [CNT_W-1:0] bubble_count;

  assign in_ctrl = '{reg_write:  in_RegWrite,
                     mem_to_reg: in_MemToReg,
                     mem_read:   in_MemRead,
                     mem_write:  in_MemWrite,
                     branch:     in_Branch,
                     alu_src:    in_ALUSrc,
                     reg_dst:    in_RegDst};

`ifdef IDEX_LOAD_USE_DETECT_EN
  load_use_detector #(.REG_W(REG_W)) u_load_use_detector (
    .ex_valid    (out_Valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rt       (out_Rt),
    .id_valid    (in_Valid),
    .id_rs       (in_Rs),
    .id_rt       (in_Rt),
    .hazard      (hazard_stall)
  );
`else
  assign hazard_stall = 1'b0;
`endif

  assign HazardStall = hazard_stall;

  // Edge decision: Flush beats Stall, Stall beats a hazard bubble; only
  // Flush and hazard bubbles are counted, never an idle (in_Valid=0) slot.
  always_comb begin
    load_bubble  = Flush | (~Stall & (hazard_stall | ~in_Valid));
    count_bubble = Flush | (~Stall & hazard_stall);
  end

  // Pipeline register: bubble clears everything, Stall holds, else load Decode.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_Valid      <= 1'b0;
      out_PCPlus4    <= '0;
      out_ReadData1  <= '0;
      out_ReadData2  <= '0;
      out_SignExtImm <= '0;
      out_Rs         <= '0;
      out_Rt         <= '0;
      out_Rd         <= '0;
      out_ALUOP      <= '0;
      ex_ctrl        <= CTRL_BUBBLE;
    end else if (load_bubble) begin
      out_Valid      <= 1'b0;
      out_PCPlus4    <= '0;
      out_ReadData1  <= '0;
      out_ReadData2  <= '0;
      out_SignExtImm <= '0;
      out_Rs         <= '0;
      out_Rt         <= '0;
      out_Rd         <= '0;
      out_ALUOP      <= '0;
      ex_ctrl        <= CTRL_BUBBLE;
    end else if (!Stall) begin
      out_Valid      <= in_Valid;
      out_PCPlus4    <= in_PCPlus4;
      out_ReadData1  <= in_ReadData1;
      out_ReadData2  <= in_ReadData2;
      out_SignExtImm <= in_SignExtImm;
      out_Rs         <= in_Rs;
      out_Rt         <= in_Rt;
      out_Rd         <= in_Rd;
      out_ALUOP      <= in_ALUOP;
      ex_ctrl        <= in_ctrl;
    end
  end

  // Bubble counter: clear wins over increment, and it sticks at all-ones.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bubble_count <= '0;
    end else if (ClrCount) begin
      bubble_count <= '0;
    end else if (count_bubble && (bubble_count != CNT_MAX)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

  assign out_RegWrite    = ex_ctrl.reg_write;
  assign out_MemToReg    = ex_ctrl.mem_to_reg;
  assign out_MemRead     = ex_ctrl.mem_read;
  assign out_MemWrite    = ex_ctrl.mem_write;
  assign out_Branch      = ex_ctrl.branch;
  assign out_ALUSrc      = ex_ctrl.alu_src;
  assign out_RegDst      = ex_ctrl.reg_dst;
  assign out_BubbleCount = bubble_count;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// tb_id_ex_stage_register: directed scoreboard bench for the ID/EX register.
// A second instance with a 2-bit counter exercises saturation on the same
// stimulus. Expectations follow IDEX_LOAD_USE_DETECT_EN when it is defined.
module tb_id_ex_stage_register;
  import pipeline_pkg::*;

`ifdef IDEX_LOAD_USE_DETECT_EN
  localparam bit DETECT = 1'b1;
`else
  localparam bit DETECT = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memToReg;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic        aluSrc;
    logic        regDst;
    logic [3:0]  aluop;
  } pipe_t;

  typedef struct packed {
    pipe_t       pipe;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;
  } exp_t;

  logic Clk, Rst_n, Stall, Flush, ClrCount;
  logic in_Valid, in_RegWrite, in_MemToReg, in_MemRead, in_MemWrite;
  logic in_Branch, in_ALUSrc, in_RegDst;
  logic [31:0] in_PCPlus4, in_ReadData1, in_ReadData2, in_SignExtImm;
  logic [4:0]  in_Rs, in_Rt, in_Rd;
  logic [3:0]  in_ALUOP;

  logic out_Valid, out_RegWrite, out_MemToReg, out_MemRead, out_MemWrite;
  logic out_Branch, out_ALUSrc, out_RegDst, HazardStall;
  logic [31:0] out_PCPlus4, out_ReadData1, out_ReadData2, out_SignExtImm;
  logic [4:0]  out_Rs, out_Rt, out_Rd;
  logic [3:0]  out_ALUOP;
  logic [15:0] out_BubbleCount;

  logic sat_Valid, sat_RegWrite, sat_MemToReg, sat_MemRead, sat_MemWrite;
  logic sat_Branch, sat_ALUSrc, sat_RegDst, sat_HazardStall;
  logic [31:0] sat_PCPlus4, sat_ReadData1, sat_ReadData2, sat_SignExtImm;
  logic [4:0]  sat_Rs, sat_Rt, sat_Rd;
  logic [3:0]  sat_ALUOP;
  logic [1:0]  sat_BubbleCount;

  pipe_t       mPipe;
  logic [15:0] mCnt16;
  logic [1:0]  mCnt2;
  exp_t        expQ[$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          seqNo      = 0;

  id_ex_stage_register #(.CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .ClrCount(ClrCount),
    .in_Valid(in_Valid), .in_PCPlus4(in_PCPlus4), .in_ReadData1(in_ReadData1),
    .in_ReadData2(in_ReadData2), .in_SignExtImm(in_SignExtImm),
    .in_Rs(in_Rs), .in_Rt(in_Rt), .in_Rd(in_Rd),
    .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg), .in_MemRead(in_MemRead),
    .in_MemWrite(in_MemWrite), .in_Branch(in_Branch), .in_ALUSrc(in_ALUSrc),
    .in_RegDst(in_RegDst), .in_ALUOP(in_ALUOP),
    .out_Valid(out_Valid), .out_PCPlus4(out_PCPlus4), .out_ReadData1(out_ReadData1),
    .out_ReadData2(out_ReadData2), .out_SignExtImm(out_SignExtImm),
    .out_Rs(out_Rs), .out_Rt(out_Rt), .out_Rd(out_Rd),
    .out_RegWrite(out_RegWrite), .out_MemToReg(out_MemToReg), .out_MemRead(out_MemRead),
    .out_MemWrite(out_MemWrite), .out_Branch(out_Branch), .out_ALUSrc(out_ALUSrc),
    .out_RegDst(out_RegDst), .out_ALUOP(out_ALUOP),
    .out_BubbleCount(out_BubbleCount), .HazardStall(HazardStall)
  );

  id_ex_stage_register #(.CNT_W(2)) dutSat (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .ClrCount(ClrCount),
    .in_Valid(in_Valid), .in_PCPlus4(in_PCPlus4), .in_ReadData1(in_ReadData1),
    .in_ReadData2(in_ReadData2), .in_SignExtImm(in_SignExtImm),
    .in_Rs(in_Rs), .in_Rt(in_Rt), .in_Rd(in_Rd),
    .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg), .in_MemRead(in_MemRead),
    .in_MemWrite(in_MemWrite), .in_Branch(in_Branch), .in_ALUSrc(in_ALUSrc),
    .in_RegDst(in_RegDst), .in_ALUOP(in_ALUOP),
    .out_Valid(sat_Valid), .out_PCPlus4(sat_PCPlus4), .out_ReadData1(sat_ReadData1),
    .out_ReadData2(sat_ReadData2), .out_SignExtImm(sat_SignExtImm),
    .out_Rs(sat_Rs), .out_Rt(sat_Rt), .out_Rd(sat_Rd),
    .out_RegWrite(sat_RegWrite), .out_MemToReg(sat_MemToReg), .out_MemRead(sat_MemRead),
    .out_MemWrite(sat_MemWrite), .out_Branch(sat_Branch), .out_ALUSrc(sat_ALUSrc),
    .out_RegDst(sat_RegDst), .out_ALUOP(sat_ALUOP),
    .out_BubbleCount(sat_BubbleCount), .HazardStall(sat_HazardStall)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic pipe_t dutPipe();
    pipe_t p;
    p = '{out_Valid, out_PCPlus4, out_ReadData1, out_ReadData2, out_SignExtImm,
          out_Rs, out_Rt, out_Rd, out_RegWrite, out_MemToReg, out_MemRead,
          out_MemWrite, out_Branch, out_ALUSrc, out_RegDst, out_ALUOP};
    return p;
  endfunction

  function automatic pipe_t satPipe();
    pipe_t p;
    p = '{sat_Valid, sat_PCPlus4, sat_ReadData1, sat_ReadData2, sat_SignExtImm,
          sat_Rs, sat_Rt, sat_Rd, sat_RegWrite, sat_MemToReg, sat_MemRead,
          sat_MemWrite, sat_Branch, sat_ALUSrc, sat_RegDst, sat_ALUOP};
    return p;
  endfunction

  function automatic pipe_t inputPipe();
    pipe_t p;
    p = '{in_Valid, in_PCPlus4, in_ReadData1, in_ReadData2, in_SignExtImm,
          in_Rs, in_Rt, in_Rd, in_RegWrite, in_MemToReg, in_MemRead,
          in_MemWrite, in_Branch, in_ALUSrc, in_RegDst, in_ALUOP};
    return p;
  endfunction

  task automatic checkOne(input string tag, input logic [159:0] observed,
                          input logic [159:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Present one Decode instruction; other fields derive from a running sequence number.
  task automatic loadInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic memRead,
                           input logic [3:0] aluop, input logic [31:0] rd1);
    logic [31:0] s;
    seqNo++;
    s = 32'(seqNo);
    in_Valid      = v;
    in_PCPlus4    = 32'h0040_0000 + (s << 2);
    in_ReadData1  = rd1;
    in_ReadData2  = rd1 ^ 32'h5A5A_1234;
    in_SignExtImm = {{16{s[0]}}, s[15:0] * 16'd3};
    in_Rs         = rs;
    in_Rt         = rt;
    in_Rd         = rd;
    in_MemRead    = memRead;
    in_MemToReg   = memRead;
    in_MemWrite   = s[1] & ~memRead;
    in_RegWrite   = ~(s[1] & ~memRead);
    in_Branch     = (aluop == ALU_SUB);
    in_ALUSrc     = memRead;
    in_RegDst     = ~memRead;
    in_ALUOP      = aluop;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    e = expQ.pop_front();
    checkOne({tag, ".valid"},   160'(out_Valid),       160'(e.pipe.valid));
    checkOne({tag, ".pipe"},    160'(dutPipe()),       160'(e.pipe));
    checkOne({tag, ".cnt16"},   160'(out_BubbleCount), 160'(e.cnt16));
    checkOne({tag, ".satPipe"}, 160'(satPipe()),       160'(e.pipe));
    checkOne({tag, ".cnt2"},    160'(sat_BubbleCount), 160'(e.cnt2));
  endtask

  // Check HazardStall against current inputs, model one edge, push, then compare.
  task automatic applyStimulus(input string tag);
    logic  hz;
    logic  inc;
    pipe_t nxt;
    exp_t  e;
    #1;
    hz = DETECT && mPipe.valid && mPipe.memRead && (mPipe.rt != 5'd0) && in_Valid &&
         ((mPipe.rt == in_Rs) || (mPipe.rt == in_Rt));
    checkOne({tag, ".hazard"}, 160'({HazardStall, sat_HazardStall}), 160'({hz, hz}));
    if (Flush)                  nxt = '0;
    else if (Stall)             nxt = mPipe;
    else if (hz || !in_Valid)   nxt = '0;
    else                        nxt = inputPipe();
    inc = Flush || (!Stall && hz);
    if (ClrCount) begin
      mCnt16 = '0;
      mCnt2  = '0;
    end else if (inc) begin
      if (mCnt16 != 16'hFFFF) mCnt16 = mCnt16 + 16'd1;
      if (mCnt2 != 2'b11)     mCnt2  = mCnt2 + 2'd1;
    end
    mPipe = nxt;
    e = '{mPipe, mCnt16, mCnt2};
    expQ.push_back(e);
    @(posedge Clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic resetModel();
    exp_t e;
    mPipe  = '0;
    mCnt16 = '0;
    mCnt2  = '0;
    e = '{mPipe, mCnt16, mCnt2};
    expQ.push_back(e);
  endtask

  initial begin
    Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0; ClrCount = 1'b0;
    loadInstr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, ALU_AND, 32'h0);
    seqNo = 0;
    repeat (2) @(posedge Clk);
    #1;
    resetModel();
    checkOutput("reset");
    Rst_n = 1'b1;

    // Normal flow, one-cycle latency
    loadInstr(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, ALU_ADD, 32'h0000_0005);
    applyStimulus("normal1");
    loadInstr(1'b1, 5'd4, 5'd5, 5'd6, 1'b0, ALU_SUB, 32'hDEAD_BEEF);
    applyStimulus("normal2");
    loadInstr(1'b0, 5'd7, 5'd9, 5'd10, 1'b1, ALU_OR, 32'h1234_5678);
    applyStimulus("idleSlot");
    loadInstr(1'b1, 5'd11, 5'd12, 5'd13, 1'b0, ALU_SLT, 32'hCAFE_0001);
    applyStimulus("normal3");

    // Stall three cycles with changing inputs, then Flush beating Stall
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      loadInstr(1'b1, 5'(i + 14), 5'(i + 17), 5'(i + 20), 1'b0, ALU_NOR, 32'h100 + 32'(i));
      applyStimulus($sformatf("stall%0d", i));
    end
    Flush = 1'b1;
    applyStimulus("flushOverStall");
    Stall = 1'b0; Flush = 1'b0;
    loadInstr(1'b1, 5'd21, 5'd22, 5'd23, 1'b1, ALU_ADD, 32'h0BAD_F00D);
    applyStimulus("afterFlush");

    // Asynchronous reset between edges, no clock needed
    #2;
    Rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("midReset");
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // Load-use via rs, then the re-presented instruction
    loadInstr(1'b1, 5'd3, 5'd8, 5'd0, 1'b1, ALU_ADD, 32'h0000_0040);
    applyStimulus("lwRt8");
    loadInstr(1'b1, 5'd8, 5'd4, 5'd9, 1'b0, ALU_ADD, 32'h0000_0077);
    applyStimulus("useRs8");
    applyStimulus("represent");
    // Load-use via rt
    loadInstr(1'b1, 5'd2, 5'd9, 5'd0, 1'b1, ALU_ADD, 32'h0000_0080);
    applyStimulus("lwRt9");
    loadInstr(1'b1, 5'd5, 5'd9, 5'd10, 1'b0, ALU_OR, 32'h0000_0099);
    applyStimulus("useRt9");
    // Load to register 0 never stalls
    loadInstr(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, ALU_ADD, 32'h0000_00C0);
    applyStimulus("lwRt0");
    loadInstr(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, ALU_ADD, 32'h0000_00C1);
    applyStimulus("useR0");

    // Saturation: clear, five flushes, then clear beating a flush
    ClrCount = 1'b1;
    applyStimulus("clear");
    ClrCount = 1'b0;
    Flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("satFlush%0d", i));
    end
    ClrCount = 1'b1;
    applyStimulus("clearOverFlush");
    ClrCount = 1'b0; Flush = 1'b0;
    loadInstr(1'b1, 5'd30, 5'd31, 5'd29, 1'b0, ALU_AND, 32'hFFFF_FFFF);
    applyStimulus("final");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
